// File: rtl/ntt_pkg.sv
// Shared constants, mode encoding and AGU state encoding for the Kyber NTT datapath.
`timescale 1ns/1ps
package ntt_pkg;

  localparam int N       = 256;
  localparam int NLAYERS = 7;
  localparam int Q       = 3329;
  localparam int INV128  = 3303;

  localparam logic MODE_NTT  = 1'b0;
  localparam logic MODE_INTT = 1'b1;

  typedef enum logic [2:0] {
    AGU_IDLE  = 3'd0,
    AGU_RUN   = 3'd1,
    AGU_GAP   = 3'd2,
    AGU_DRAIN = 3'd3,
    AGU_DONE  = 3'd4
  } agu_state_e;

  // log2 of the butterfly span L: NTT shrinks from 128 to 2, INTT grows from 2 to 128.
  function automatic logic [2:0] layer_log2_len(input logic mode, input logic [2:0] layer);
    if (mode == MODE_INTT) begin
      return layer + 3'd1;
    end
    return 3'd7 - layer;
  endfunction

endpackage

// File: rtl/ntt_addr_map.sv
// Combinational butterfly address / twiddle index map: (mode, layer, j) -> (up, dn, zeta_idx).
`timescale 1ns/1ps
module ntt_addr_map
  import ntt_pkg::*;
(
  input  logic       mode,
  input  logic [2:0] layer,
  input  logic [6:0] j,
  output logic [7:0] up,
  output logic [7:0] dn,
  output logic [6:0] zeta_idx
);

  logic [2:0] s;
  logic [6:0] mask;
  logic [6:0] g;
  logic [6:0] o;
  logic [7:0] len;

  always_comb begin
    s    = layer_log2_len(mode, layer);
    len  = 8'd1 << s;
    // For s = 7 the 7-bit shift wraps to 0, so the mask becomes all ones as wanted.
    mask = (7'd1 << s) - 7'd1;
    g    = j >> s;
    o    = j & mask;
    up   = ({1'b0, g} << ({1'b0, s} + 4'd1)) | {1'b0, o};
    // o < L, so bit s of up is always clear and the add reduces to an OR.
    dn   = up | len;
    if (mode == MODE_INTT) begin
      // 256/L - 1 - g evaluated mod 128; the wrap at L = 2 lands exactly on 127 - g.
      zeta_idx = (7'd1 << (4'd8 - {1'b0, s})) - 7'd1 - g;
    end else begin
      zeta_idx = (7'd1 << (3'd7 - s)) + g;
    end
  end

endmodule

// File: rtl/ntt_agu.sv
// NTT/INTT address-generation unit: walks 7 layers x 128 butterflies with a drain gap between layers.
`timescale 1ns/1ps
module ntt_agu
  import ntt_pkg::*;
#(
  parameter int STAGE_GAP = 6  // legal range 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_sel,
  input  logic       i_stall,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_e,
  output logic       o_last_e,
  output logic       o_sel,
  output logic [7:0] o_addr_up_e,
  output logic [7:0] o_addr_dn_e,
  output logic [6:0] o_zeta_idx,
  output logic [2:0] o_layer,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] ST_IDLE  = 3'(AGU_IDLE);
  localparam logic [2:0] ST_RUN   = 3'(AGU_RUN);
  localparam logic [2:0] ST_GAP   = 3'(AGU_GAP);
  localparam logic [2:0] ST_DRAIN = 3'(AGU_DRAIN);
  localparam logic [2:0] ST_DONE  = 3'(AGU_DONE);

  localparam logic [3:0] GAP_LAST   = 4'(STAGE_GAP - 1);
  localparam logic [3:0] DRAIN_LAST = 4'(STAGE_GAP);
  localparam logic [2:0] LAST_LAYER = 3'(NLAYERS - 1);

  logic [2:0] state_q, state_d;
  logic [6:0] j_q, j_d;
  logic [2:0] layer_q, layer_d;
  logic [3:0] gap_q, gap_d;
  logic       sel_q;

  logic       accept;
  logic       run_mode;
  logic       issue;
  logic [7:0] up_w, dn_w;
  logic [6:0] zeta_w;

  logic       busy_q, done_q, e_q, last_e_q;
  logic [7:0] up_q, dn_q;
  logic [6:0] zeta_q;
  logic [2:0] layer_out_q;

  // Start acceptance doubles as the first issue slot of layer 0 so o_e follows start by one cycle.
  assign accept   = (state_q == ST_IDLE) && i_start;
  assign run_mode = accept ? i_sel : sel_q;
  assign issue    = (accept || (state_q == ST_RUN)) && !i_stall;

  ntt_addr_map u_addr_map (
    .mode     (run_mode),
    .layer    (layer_q),
    .j        (j_q),
    .up       (up_w),
    .dn       (dn_w),
    .zeta_idx (zeta_w)
  );

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    layer_d = layer_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) state_d = ST_RUN;
      end
      ST_RUN: begin
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_RUN;
          layer_d = layer_q + 3'd1;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      ST_DRAIN: begin
        // One cycle longer than a layer gap so DONE is seen after the final writeback settles.
        if (gap_q == DRAIN_LAST) begin
          state_d = ST_DONE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        layer_d = '0;
        j_d     = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (issue) begin
      j_d = j_q + 7'd1;
      if (j_q == 7'd127) begin
        state_d = (layer_q == LAST_LAYER) ? ST_DRAIN : ST_GAP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      j_q     <= '0;
      layer_q <= '0;
      gap_q   <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      layer_q <= layer_d;
      gap_q   <= gap_d;
      if (accept) sel_q <= i_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      e_q         <= 1'b0;
      last_e_q    <= 1'b0;
      up_q        <= '0;
      dn_q        <= '0;
      zeta_q      <= '0;
      layer_out_q <= '0;
    end else begin
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_d == ST_DONE);
      e_q      <= issue;
      last_e_q <= issue && (layer_q == LAST_LAYER);
      if (issue) begin
        up_q        <= up_w;
        dn_q        <= dn_w;
        zeta_q      <= zeta_w;
        layer_out_q <= layer_q;
      end
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_e         = e_q;
  assign o_last_e    = last_e_q;
  assign o_sel       = sel_q;
  assign o_addr_up_e = up_q;
  assign o_addr_dn_e = dn_q;
  assign o_zeta_idx  = zeta_q;
  assign o_layer     = layer_out_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ntt_agu.sv
// Self-checking bench for ntt_agu: arithmetic butterfly model, cycle schedule model, scoreboard queue.
`timescale 1ns/1ps
module tb_ntt_agu;

  localparam int G = 6;
  localparam int W = 27;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_start, i_sel, i_stall;
  logic       o_busy, o_done, o_e, o_last_e, o_sel;
  logic [7:0] o_addr_up_e, o_addr_dn_e;
  logic [6:0] o_zeta_idx;
  logic [2:0] o_layer;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int prints = 0;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  logic [W-1:0] obs[int];

  ntt_agu #(.STAGE_GAP(G)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_sel       (i_sel),
    .i_stall     (i_stall),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_e         (o_e),
    .o_last_e    (o_last_e),
    .o_sel       (o_sel),
    .o_addr_up_e (o_addr_up_e),
    .o_addr_dn_e (o_addr_dn_e),
    .o_zeta_idx  (o_zeta_idx),
    .o_layer     (o_layer),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] pack_bf(input logic last, input logic [2:0] layer,
                                           input logic [7:0] up, input logic [7:0] dn,
                                           input logic [6:0] k);
    return {last, layer, up, dn, k};
  endfunction

  function automatic logic [W-1:0] model_bf(input bit mode, input int layer, input int j);
    int len, g, o, up, dn, k;
    len = mode ? (2 << layer) : (128 >> layer);
    g   = j / len;
    o   = j % len;
    up  = 2 * len * g + o;
    dn  = up + len;
    k   = mode ? (256 / len - 1 - g) : (128 / len + g);
    return pack_bf(layer == 6, 3'(layer), 8'(up), 8'(dn), 7'(k));
  endfunction

  function automatic logic [33:0] all_outs();
    return {o_busy, o_done, o_e, o_last_e, o_sel, o_addr_up_e, o_addr_dn_e,
            o_zeta_idx, o_layer, dbg_state};
  endfunction

  // ---------------- driver + scoreboard for one full transform ----------------
  // Cycle c = outputs seen after the c-th rising edge following the start edge.
  task automatic do_run(input bit mode, input int stall_lo, input int stall_n,
                        input int pulse_cyc, input bit hold_start,
                        output int done_seen, output int first_next);
    int t, exp_done, busy_bad, sel_bad, cov_bad, c, want_c;
    int hits[8][256];
    logic [W-1:0] got, want;
    exp_q.delete();
    exp_cyc_q.delete();
    obs.delete();
    t = 0;
    for (int l = 0; l < 7; l++) begin
      for (int j = 0; j < 128; j++) begin
        while (t >= stall_lo && t < stall_lo + stall_n) t++;
        exp_q.push_back(model_bf(mode, l, j));
        exp_cyc_q.push_back(t + 1);
        t++;
      end
      if (l < 6) t += G;
    end
    exp_done = t + G + 1;
    for (int l = 0; l < 8; l++)
      for (int a = 0; a < 256; a++) hits[l][a] = 0;
    busy_bad   = 0;
    sel_bad    = 0;
    cov_bad    = 0;
    done_seen  = -1;
    first_next = -1;

    @(negedge clk);
    i_sel   = mode;
    i_start = 1'b1;
    i_stall = 1'b0;
    @(posedge clk);
    for (c = 1; c <= 3000; c++) begin
      @(negedge clk);
      if (done_seen < 0 || c == done_seen + 1) begin
        if (o_busy !== (done_seen < 0)) busy_bad++;
      end
      if (done_seen >= 0 && c == done_seen + 1 && o_done !== 1'b0) busy_bad++;
      if (done_seen < 0 && o_sel !== mode) sel_bad++;
      if (o_e === 1'b1) begin
        if (done_seen >= 0) begin
          if (first_next < 0) first_next = c;
        end else begin
          got    = {o_last_e, o_layer, o_addr_up_e, o_addr_dn_e, o_zeta_idx};
          obs[c] = got;
          hits[o_layer][o_addr_up_e]++;
          hits[o_layer][o_addr_dn_e]++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            if (prints < 20) $display("FAIL butterfly_extra: cycle %0d got %h, expected none", c, got);
            prints++;
          end else begin
            want   = exp_q.pop_front();
            want_c = exp_cyc_q.pop_front();
            if (got !== want || c != want_c) begin
              errors++;
              if (prints < 20)
                $display("FAIL butterfly: cycle %0d got %h, expected %h at cycle %0d", c, got, want, want_c);
              prints++;
            end
          end
        end
      end
      if (o_done === 1'b1 && done_seen < 0) done_seen = c;
      i_stall = (c >= stall_lo && c < stall_lo + stall_n);
      i_sel   = (c == pulse_cyc) ? ~mode : mode;
      i_start = (c == pulse_cyc) || (hold_start && c >= exp_done - 3);
      if (done_seen >= 0 && ((!hold_start && c >= done_seen + 2) || first_next >= 0)) break;
    end
    i_start = 1'b0;
    i_stall = 1'b0;
    i_sel   = 1'b0;

    for (int l = 0; l < 7; l++)
      for (int a = 0; a < 256; a++)
        if (hits[l][a] != 1) cov_bad++;

    checks++;
    if (done_seen != exp_done) begin
      errors++;
      $display("FAIL done_cycle: got %0d, expected %0d", done_seen, exp_done);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_butterflies: %0d not issued, expected 0", exp_q.size());
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL busy_done_window: %0d bad cycles, expected 0", busy_bad);
    end
    checks++;
    if (sel_bad != 0) begin
      errors++;
      $display("FAIL sel_hold: %0d bad cycles, expected 0", sel_bad);
    end
    checks++;
    if (cov_bad != 0) begin
      errors++;
      $display("FAIL address_coverage: %0d (layer,addr) slots not hit once, expected 0", cov_bad);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int bad;
    rst_n   = 1'b0;
    i_start = 1'b0;
    i_sel   = 1'b0;
    i_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, expected 0", all_outs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (o_e !== 1'b0 || o_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_after_reset: %0d active cycles, expected 0", bad);
    end
  endtask

  task automatic test_ntt_basic();
    int d, f;
    int cyc[4];
    logic [W-1:0] want[4];
    logic [W-1:0] got;
    do_run(1'b0, 0, 0, -1, 1'b0, d, f);
    cyc[0] = 1;   want[0] = pack_bf(1'b0, 3'd0, 8'd0, 8'd128, 7'd1);
    cyc[1] = 135; want[1] = pack_bf(1'b0, 3'd1, 8'd0, 8'd64,  7'd2);
    cyc[2] = 806; want[2] = pack_bf(1'b1, 3'd6, 8'd1, 8'd3,   7'd64);
    // j=2 is the first layer-6 butterfly in group g=1.
    cyc[3] = 807; want[3] = pack_bf(1'b1, 3'd6, 8'd4, 8'd6,   7'd65);
    for (int i = 0; i < 4; i++) begin
      got = obs.exists(cyc[i]) ? obs[cyc[i]] : 'x;
      checks++;
      if (got !== want[i]) begin
        errors++;
        $display("FAIL ntt_point: cycle %0d got %h, expected %h", cyc[i], got, want[i]);
      end
    end
    checks++;
    if (d != 939) begin
      errors++;
      $display("FAIL ntt_done_939: got %0d, expected 939", d);
    end
  endtask

  task automatic test_intt_basic();
    int d, f;
    int cyc[4];
    logic [W-1:0] want[4];
    logic [W-1:0] got;
    do_run(1'b1, 0, 0, -1, 1'b0, d, f);
    cyc[0] = 1;   want[0] = pack_bf(1'b0, 3'd0, 8'd0, 8'd2,   7'd127);
    cyc[1] = 2;   want[1] = pack_bf(1'b0, 3'd0, 8'd1, 8'd3,   7'd127);
    cyc[2] = 3;   want[2] = pack_bf(1'b0, 3'd0, 8'd4, 8'd6,   7'd126);
    cyc[3] = 810; want[3] = pack_bf(1'b1, 3'd6, 8'd5, 8'd133, 7'd1);
    for (int i = 0; i < 4; i++) begin
      got = obs.exists(cyc[i]) ? obs[cyc[i]] : 'x;
      checks++;
      if (got !== want[i]) begin
        errors++;
        $display("FAIL intt_point: cycle %0d got %h, expected %h", cyc[i], got, want[i]);
      end
    end
    checks++;
    if (d != 939) begin
      errors++;
      $display("FAIL intt_done_939: got %0d, expected 939", d);
    end
  endtask

  task automatic test_stall();
    int d, f;
    do_run(1'b0, 300, 3, -1, 1'b0, d, f);
    checks++;
    if (d != 942) begin
      errors++;
      $display("FAIL stall_done_942: got %0d, expected 942", d);
    end
  endtask

  task automatic test_start_ignored();
    int d, f;
    do_run(1'b0, 0, 0, 50, 1'b0, d, f);
    checks++;
    if (d != 939) begin
      errors++;
      $display("FAIL start_while_busy: done got %0d, expected 939", d);
    end
  endtask

  task automatic test_reset_mid_run();
    int d, f, bad;
    @(negedge clk);
    i_sel   = 1'b0;
    i_start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      i_start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL reset_mid_run: got %h, expected 0", all_outs());
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (7) begin
      @(negedge clk);
      if (o_e !== 1'b0 || o_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL partial_issue_after_reset: %0d active cycles, expected 0", bad);
    end
    do_run(1'b0, 0, 0, -1, 1'b0, d, f);
    checks++;
    if (d != 939) begin
      errors++;
      $display("FAIL rerun_after_reset: done got %0d, expected 939", d);
    end
  endtask

  task automatic test_back_to_back();
    int d, f;
    bit mode;
    mode = 1'($urandom_range(0, 1));
    do_run(mode, 0, 0, -1, 1'b1, d, f);
    checks++;
    if (f != d + 2 || d < 0) begin
      errors++;
      $display("FAIL back_to_back: next first o_e at %0d, expected %0d", f, d + 2);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int d, f, lo, n;
    bit mode;
    for (int r = 0; r < 3; r++) begin
      mode = 1'($urandom_range(0, 1));
      lo   = $urandom_range(1, 930);
      n    = $urandom_range(1, 6);
      do_run(mode, lo, n, -1, 1'b0, d, f);
    end
  endtask

  initial begin
    test_reset();
    test_ntt_basic();
    test_intt_basic();
    test_stall();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
